// File: rtl/cordic_rotator.sv
// Fully pipelined CORDIC vector rotator.
// Rotates (x, y) by angle a and removes the CORDIC gain. One sample is
// accepted every clock. Each result appears ITERATIONS+4 clocks after its
// sample is taken.
// Register chain: input capture, angle wrap, quadrant fold, ITERATIONS
// micro-rotations, gain multiply, round/saturate.
// Internal words are signed, with 16 fraction bits and IW-17 integer bits.
module cordic_rotator #(
    parameter int ITERATIONS = 14,
    parameter int IW         = 20
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [12:0] a,
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic [9:0]  xo,
    output logic [9:0]  yo
);

    // Port formats: width / fraction bits
    localparam int AW = 13;
    localparam int AF = 10;
    localparam int XW = 12;
    localparam int XF = 10;
    localparam int OW = 10;
    localparam int OF = 8;
    // Internal fraction bits
    localparam int FB = 16;
    // 1/K as an unsigned Q1.17 value held in an 18-bit signed constant
    localparam int GAIN_FB = 17;

    typedef logic signed [IW-1:0] word_t;

    localparam word_t PI      = word_t'(205887);
    localparam word_t TWO_PI  = word_t'(411775);
    localparam word_t HALF_PI = word_t'(102944);
    localparam logic signed [17:0] INV_GAIN = 18'sd79594;

    // Returns atan(2^-i) in Q16, rounded to nearest.
    // From i = 6 onward the value rounds to exactly 2^(16-i).
    function automatic word_t atan_entry(input int i);
        case (i)
            0:       return word_t'(51472);
            1:       return word_t'(30386);
            2:       return word_t'(16055);
            3:       return word_t'(8150);
            4:       return word_t'(4091);
            5:       return word_t'(2047);
            default: return (i > FB) ? '0 : (word_t'(1) <<< (FB - i));
        endcase
    endfunction

    // Multiplies v by 1/K. The wide product is scaled back to the internal format.
    function automatic word_t apply_gain(input word_t v);
        logic signed [IW+17:0] p;
        p = (IW+18)'(v) * (IW+18)'(INV_GAIN);
        return word_t'(p >>> GAIN_FB);
    endfunction

    // Rounds half-up to OF fraction bits.
    // The result is clamped to the OW-bit signed output range.
    function automatic logic [OW-1:0] round_sat(input word_t v);
        logic signed [IW:0]         sum;
        logic signed [IW-FB+OF:0]   q;
        int                         qi;
        sum = {v[IW-1], v} + (IW+1)'(1 << (FB - OF - 1));
        q   = (IW-FB+OF+1)'(sum >>> (FB - OF));
        qi  = int'(q);
        if (qi > 2**(OW-1) - 1) return {1'b0, {(OW-1){1'b1}}};
        if (qi < -(2**(OW-1)))  return {1'b1, {(OW-1){1'b0}}};
        return OW'(qi);
    endfunction

    logic [AW-1:0] a_r;
    logic [XW-1:0] x_r;
    logic [XW-1:0] y_r;
    word_t         a_ext, x_ext, y_ext;
    word_t         w_x, w_y, w_z;
    word_t         xs [ITERATIONS+1];
    word_t         ys [ITERATIONS+1];
    word_t         zs [ITERATIONS];
    word_t         g_x, g_y;

    // Capture the raw ports on every edge. There is no handshake.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            a_r <= '0;
            x_r <= '0;
            y_r <= '0;
        end else begin
            // NOTE: clocked state uses <= so every stage samples the previous stage's old value.
            a_r <= a;
            x_r <= x;
            y_r <= y;
        end
    end

    // Sign-extend each operand and left-align it to the internal Q16 format.
    assign a_ext = {{(IW-AW-(FB-AF)){a_r[AW-1]}}, a_r, {(FB-AF){1'b0}}};
    assign x_ext = {{(IW-XW-(FB-XF)){x_r[XW-1]}}, x_r, {(FB-XF){1'b0}}};
    assign y_ext = {{(IW-XW-(FB-XF)){y_r[XW-1]}}, y_r, {(FB-XF){1'b0}}};

    // Wrap the angle into [-pi, pi]. One correction is enough because |a| < 4.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            w_x <= '0;
            w_y <= '0;
            w_z <= '0;
        end else begin
            w_x <= x_ext;
            w_y <= y_ext;
            if (a_ext > PI)
                w_z <= a_ext - TWO_PI;
            else if (a_ext < -PI)
                w_z <= a_ext + TWO_PI;
            else
                w_z <= a_ext;
        end
    end

    // Fold the angle into [-pi/2, pi/2] by a half turn, then run the micro-rotation chain.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            // NOTE: these register arrays are a pipeline, not RAM, so clearing them on reset
            // is what discards in-flight samples.
            for (int i = 0; i <= ITERATIONS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
            for (int i = 0; i < ITERATIONS; i++)
                zs[i] <= '0;
        end else begin
            if (w_z > HALF_PI) begin
                xs[0] <= -w_x;
                ys[0] <= -w_y;
                zs[0] <= w_z - PI;
            end else if (w_z < -HALF_PI) begin
                xs[0] <= -w_x;
                ys[0] <= -w_y;
                zs[0] <= w_z + PI;
            end else begin
                xs[0] <= w_x;
                ys[0] <= w_y;
                zs[0] <= w_z;
            end

            for (int i = 0; i < ITERATIONS; i++) begin
                if (zs[i][IW-1]) begin
                    xs[i+1] <= xs[i] + (ys[i] >>> i);
                    ys[i+1] <= ys[i] - (xs[i] >>> i);
                end else begin
                    xs[i+1] <= xs[i] - (ys[i] >>> i);
                    ys[i+1] <= ys[i] + (xs[i] >>> i);
                end
            end

            // The final residual angle is not needed, so z stops one stage short.
            for (int i = 0; i < ITERATIONS - 1; i++)
                zs[i+1] <= zs[i][IW-1] ? zs[i] + atan_entry(i) : zs[i] - atan_entry(i);
        end
    end

    // Remove the accumulated CORDIC gain K.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            g_x <= '0;
            g_y <= '0;
        end else begin
            g_x <= apply_gain(xs[ITERATIONS]);
            g_y <= apply_gain(ys[ITERATIONS]);
        end
    end

    // Round and saturate the result into the registered outputs.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            xo <= '0;
            yo <= '0;
        end else begin
            xo <= round_sat(g_x);
            yo <= round_sat(g_y);
        end
    end

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed testbench for cordic_rotator.
// Expected outputs are in output LSBs (1/256), hand-computed from cos/sin.
module tb_cordic_rotator;

    localparam int LAT = 18;

    logic        clk;
    logic        areset;
    logic [12:0] a;
    logic [11:0] x;
    logic [11:0] y;
    logic [9:0]  xo;
    logic [9:0]  yo;

    int checks = 0;
    int errors = 0;

    cordic_rotator dut (
        .clk    (clk),
        .areset (areset),
        .a      (a),
        .x      (x),
        .y      (y),
        .xo     (xo),
        .yo     (yo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare an observed value against an expected value within +/- tol.
    task automatic check(input string tag, input int got, input int exp, input int tol);
        checks++;
        if (got < exp - tol || got > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic drive(input logic [12:0] av, input logic [11:0] xv, input logic [11:0] yv);
        a = av;
        x = xv;
        y = yv;
    endtask

    function automatic int sxo();
        return int'($signed(xo));
    endfunction

    function automatic int syo();
        return int'($signed(yo));
    endfunction

    // Hold a vector, let it travel the full pipeline, then check both outputs.
    task automatic run_vector(input string tag, input logic [12:0] av, input logic [11:0] xv,
                              input logic [11:0] yv, input int ex, input int ey,
                              input int tx, input int ty);
        drive(av, xv, yv);
        repeat (LAT + 1) @(posedge clk);
        #1;
        check({tag, " xo"}, sxo(), ex, tx);
        check({tag, " yo"}, syo(), ey, ty);
    endtask

    initial begin
        areset = 1'b1;
        drive('0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset xo", sxo(), 0, 0);
        check("reset yo", syo(), 0, 0);
        @(negedge clk);
        areset = 1'b0;
        @(posedge clk);
        #1;

        // Quarter turn: check that the result is not visible one clock early.
        drive(13'h0648, 12'h200, 12'h000);
        repeat (LAT) @(posedge clk);
        #1;
        check("quarter early yo", syo(), 0, 0);
        @(posedge clk);
        #1;
        check("quarter xo", sxo(), 0, 2);
        check("quarter yo", syo(), 128, 2);

        run_vector("identity",    13'h0000, 12'h100, 12'h200,   64,  128, 2, 2);
        run_vector("half turn",   13'h0C91, 12'h200, 12'h000, -128,    0, 2, 2);
        run_vector("wrap +4.0",   13'h0FFF, 12'h200, 12'h000,  -83,  -97, 2, 2);
        run_vector("angle +2.0",  13'h0800, 12'h200, 12'h000,  -53,  116, 2, 2);
        run_vector("angle -2.0",  13'h1800, 12'h200, 12'h000,  -53, -116, 2, 2);
        run_vector("minus pi/2",  13'h19B8, 12'h200, 12'h000,    0, -128, 2, 2);
        run_vector("sat pos",     13'h0324, 12'h7FF, 12'h7FF,    0,  511, 2, 0);
        run_vector("sat neg",     13'h0324, 12'h800, 12'h800,    0, -512, 2, 0);

        // Streaming at pi/2. Input k = (4*(23k-400), 4*(300-17k)) rotates to
        // xo = 17k-300, yo = 23k-400. One new sample is applied per clock.
        for (int c = 0; c < 36 + LAT; c++) begin
            if (c < 36)
                drive(13'h0648, 12'(4 * (23 * c - 400)), 12'(4 * (300 - 17 * c)));
            @(posedge clk);
            #1;
            if (c >= LAT) begin
                check($sformatf("stream %0d xo", c - LAT), sxo(), 17 * (c - LAT) - 300, 2);
                check($sformatf("stream %0d yo", c - LAT), syo(), 23 * (c - LAT) - 400, 2);
            end
        end

        // Reset mid-stream: outputs must clear without a clock edge.
        drive(13'h0648, 12'h200, 12'h100);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("pre-reset xo", sxo(), -64, 2);
        check("pre-reset yo", syo(), 128, 2);
        drive(13'h0648, 12'h300, 12'h0C0);
        @(posedge clk);
        #2;
        areset = 1'b1;
        #1;
        check("async reset xo", sxo(), 0, 0);
        check("async reset yo", syo(), 0, 0);
        drive(13'h0648, 12'h000, 12'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("flush %0d xo", c), sxo(), 0, 0);
            check($sformatf("flush %0d yo", c), syo(), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
